// File: rtl/dfx_rm_seq.sv
// rtl/dfx_rm_seq.sv - DFX reconfigurable-module shutdown/decouple/reset sequencer
module dfx_rm_seq #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int RST_CYC     = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk100,
    input  logic             rstn,
    input  logic             pr_req_i,
    input  logic             in_shutdown_i,
    input  logic             clr_fault_i,
    output logic             request_shutdown_o,
    output logic             decouple_o,
    output logic             rm_rstn_o,
    output logic             fault_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] reconf_cnt_o
);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHDN  = 3'd1,
        S_DECPL = 3'd2,
        S_RMRST = 3'd3,
        S_REL   = 3'd4,
        S_FAULT = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] timer;
    logic             pr_q;
    logic             start;
    logic             cnt_inc;
    logic             req_nx;
    logic             dec_nx;
    logic             rstn_nx;
    logic             fault_nx;

    // Only a rising PR request level launches a sequence.
    assign start   = pr_req_i & ~pr_q;
    assign state_o = state;

    // Next-state decision; the timer is shared by the timeout and RM-reset windows.
    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_SHDN;
            end
            S_SHDN: begin
                // A quiesce report on the last allowed cycle still counts as success.
                if (in_shutdown_i)          state_nx = S_DECPL;
                else if (timer == TMO_LAST) state_nx = S_FAULT;
            end
            S_DECPL: begin
                // Bitstream load may take arbitrarily long; wait for the request to drop.
                if (!pr_req_i) state_nx = S_RMRST;
            end
            S_RMRST: begin
                if (timer == RST_LAST) state_nx = S_REL;
            end
            S_REL: begin
                if (!in_shutdown_i) begin
                    state_nx = S_IDLE;
                    cnt_inc  = 1'b1;
                end else if (timer == TMO_LAST) begin
                    state_nx = S_FAULT;
                end
            end
            S_FAULT: begin
                // Clearing while a request is still active would immediately re-launch; refuse it.
                if (clr_fault_i && !pr_req_i) state_nx = S_IDLE;
            end
            default: state_nx = S_FAULT;
        endcase
    end

    // Output decode from the next state so registered outputs match the state they accompany.
    always_comb begin
        req_nx   = 1'b0;
        dec_nx   = 1'b0;
        rstn_nx  = 1'b1;
        fault_nx = 1'b0;
        case (state_nx)
            S_SHDN: begin
                req_nx = 1'b1;
            end
            S_DECPL: begin
                req_nx = 1'b1;
                dec_nx = 1'b1;
            end
            S_RMRST: begin
                req_nx  = 1'b1;
                dec_nx  = 1'b1;
                rstn_nx = 1'b0;
            end
            S_FAULT: begin
                req_nx   = 1'b1;
                dec_nx   = 1'b1;
                rstn_nx  = 1'b0;
                fault_nx = 1'b1;
            end
            default: begin
                req_nx = 1'b0;
            end
        endcase
    end

    // State, request edge history and the saturating dwell timer (cleared on every state change).
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            pr_q  <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_nx;
            pr_q  <= pr_req_i;
            if (state_nx != state)  timer <= '0;
            else if (timer != '1)   timer <= timer + TMR_W'(1);
        end
    end

    // Registered outputs and the completed-reconfiguration counter.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            request_shutdown_o <= 1'b0;
            decouple_o         <= 1'b0;
            rm_rstn_o          <= 1'b0;
            fault_o            <= 1'b0;
            reconf_cnt_o       <= '0;
        end else begin
            request_shutdown_o <= req_nx;
            decouple_o         <= dec_nx;
            rm_rstn_o          <= rstn_nx;
            fault_o            <= fault_nx;
            if (cnt_inc) reconf_cnt_o <= reconf_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dfx_rm_seq.sv
// tb/tb_dfx_rm_seq.sv - self-checking bench for dfx_rm_seq
module tb_dfx_rm_seq;
    localparam int TMO  = 1024;
    localparam int RSTC = 16;
    localparam int CW   = 8;

    logic          clk100 = 1'b0;
    logic          rstn = 1'b0;
    logic          pr_req_i = 1'b0;
    logic          in_shutdown_i = 1'b0;
    logic          clr_fault_i = 1'b0;
    logic          request_shutdown_o;
    logic          decouple_o;
    logic          rm_rstn_o;
    logic          fault_o;
    logic [2:0]    state_o;
    logic [CW-1:0] reconf_cnt_o;

    dfx_rm_seq #(.TIMEOUT_CYC(TMO), .RST_CYC(RSTC), .CNT_W(CW)) dut (
        .clk100             (clk100),
        .rstn               (rstn),
        .pr_req_i           (pr_req_i),
        .in_shutdown_i      (in_shutdown_i),
        .clr_fault_i        (clr_fault_i),
        .request_shutdown_o (request_shutdown_o),
        .decouple_o         (decouple_o),
        .rm_rstn_o          (rm_rstn_o),
        .fault_o            (fault_o),
        .state_o            (state_o),
        .reconf_cnt_o       (reconf_cnt_o)
    );

    always #5 clk100 = ~clk100;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number, the cycle it was entered, and derived outputs.
    int m_st, m_entry, m_cyc, m_cnt;
    bit m_prq, m_req, m_dec, m_rstn, m_fault;

    typedef struct {
        bit pr; bit shd; bit clr; int rep;
        int st; bit req; bit dec; bit rrn; bit flt; int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_outs();
        m_req   = (m_st == 1) || (m_st == 2) || (m_st == 3) || (m_st == 7);
        m_dec   = (m_st == 2) || (m_st == 3) || (m_st == 7);
        m_rstn  = !((m_st == 3) || (m_st == 7));
        m_fault = (m_st == 7);
    endtask

    task automatic model_reset();
        m_st = 0; m_prq = 0; m_cnt = 0; m_entry = m_cyc;
        m_req = 0; m_dec = 0; m_rstn = 0; m_fault = 0;
    endtask

    task automatic model_edge(input bit pr, input bit shd, input bit clr);
        int nx;
        int dwell;
        bit st_pulse;
        nx = m_st;
        st_pulse = pr && !m_prq;
        m_cyc++;
        dwell = m_cyc - m_entry - 1;
        m_prq = pr;
        case (m_st)
            0: if (st_pulse) nx = 1;
            1: if (shd) nx = 2; else if (dwell == TMO - 1) nx = 7;
            2: if (!pr) nx = 3;
            3: if (dwell == RSTC - 1) nx = 4;
            4: if (!shd) begin nx = 0; m_cnt = (m_cnt + 1) % (1 << CW); end
               else if (dwell == TMO - 1) nx = 7;
            7: if (clr && !pr) nx = 0;
            default: nx = 7;
        endcase
        if (nx != m_st) m_entry = m_cyc;
        m_st = nx;
        model_outs();
    endtask

    task automatic chk_model();
        chk("m.state", int'(state_o), m_st);
        chk("m.req", int'(request_shutdown_o), int'(m_req));
        chk("m.dec", int'(decouple_o), int'(m_dec));
        chk("m.rmrstn", int'(rm_rstn_o), int'(m_rstn));
        chk("m.fault", int'(fault_o), int'(m_fault));
        chk("m.cnt", int'(reconf_cnt_o), m_cnt);
    endtask

    task automatic step();
        @(posedge clk100);
        if (rstn) model_edge(pr_req_i, in_shutdown_i, clr_fault_i);
        #1;
        chk_model();
    endtask

    task automatic full_seq();
        pr_req_i = 1; step();
        in_shutdown_i = 1; step();
        pr_req_i = 0; step();
        repeat (RSTC) step();
        in_shutdown_i = 0; step();
    endtask

    initial begin
        int n;
        int c0;
        int lows;
        int seq[$];
        int last;

        //                pr shd clr rep st req dec rrn flt cnt
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  4, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 15, 3, 1'b1, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  2, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0,  2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1});

        m_cyc = 0;
        model_reset();
        #2;
        chk("rst.state", int'(state_o), 0);
        chk("rst.req", int'(request_shutdown_o), 0);
        chk("rst.dec", int'(decouple_o), 0);
        chk("rst.rmrstn", int'(rm_rstn_o), 0);
        chk("rst.fault", int'(fault_o), 0);
        chk("rst.cnt", int'(reconf_cnt_o), 0);
        #1 rstn = 1;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                pr_req_i = tbl[i].pr; in_shutdown_i = tbl[i].shd; clr_fault_i = tbl[i].clr;
                step();
                chk($sformatf("vec%0d.state", i), int'(state_o), tbl[i].st);
                chk($sformatf("vec%0d.req", i), int'(request_shutdown_o), int'(tbl[i].req));
                chk($sformatf("vec%0d.dec", i), int'(decouple_o), int'(tbl[i].dec));
                chk($sformatf("vec%0d.rmrstn", i), int'(rm_rstn_o), int'(tbl[i].rrn));
                chk($sformatf("vec%0d.fault", i), int'(fault_o), int'(tbl[i].flt));
                chk($sformatf("vec%0d.cnt", i), int'(reconf_cnt_o), tbl[i].cnt);
            end
        end
        clr_fault_i = 0;

        // Nominal: request, quiesce 5 cycles later, request drops 20 cycles after that.
        c0 = m_cnt; lows = 0; last = 0;
        for (int k = 0; k < 60; k++) begin
            pr_req_i = (k < 25);
            in_shutdown_i = (k >= 5) && (k < 50);
            step();
            if (int'(state_o) != last) begin
                seq.push_back(int'(state_o));
                last = int'(state_o);
            end
            if (!rm_rstn_o) lows++;
        end
        chk("nom.nstates", seq.size(), 5);
        if (seq.size() == 5) begin
            chk("nom.s0", seq[0], 1); chk("nom.s1", seq[1], 2); chk("nom.s2", seq[2], 3);
            chk("nom.s3", seq[3], 4); chk("nom.s4", seq[4], 0);
        end
        chk("nom.rst_low", lows, RSTC);
        chk("nom.cnt", int'(reconf_cnt_o), (c0 + 1) % (1 << CW));

        // SHDN timeout and fault clearing.
        pr_req_i = 1; in_shutdown_i = 0; step();
        chk("tmo.entry", int'(state_o), 1);
        n = 0;
        while (state_o != 3'd7 && n < TMO + 50) begin step(); n++; end
        chk("tmo.cycles", n, TMO);
        chk("tmo.outs", int'({request_shutdown_o, decouple_o, rm_rstn_o, fault_o}), 4'b1101);
        clr_fault_i = 1; step();
        chk("tmo.clr_ignored", int'(state_o), 7);
        clr_fault_i = 0; pr_req_i = 0; step();
        clr_fault_i = 1; step();
        chk("tmo.clr_state", int'(state_o), 0);
        chk("tmo.clr_fault", int'(fault_o), 0);
        clr_fault_i = 0;

        // Quiesce report on the final allowed cycle wins over the timeout.
        pr_req_i = 1; step();
        repeat (TMO - 1) step();
        in_shutdown_i = 1; step();
        chk("simul.state", int'(state_o), 2);
        pr_req_i = 0; step();
        repeat (RSTC) step();
        in_shutdown_i = 0; step();
        chk("simul.done", int'(state_o), 0);

        // Extra request edges in DECPL and REL are dropped.
        c0 = m_cnt;
        pr_req_i = 1; step();
        pr_req_i = 0; step();
        in_shutdown_i = 1; step();
        chk("retrig.decpl", int'(state_o), 2);
        pr_req_i = 1; step();
        chk("retrig.decpl_hold", int'(state_o), 2);
        repeat (3) step();
        pr_req_i = 0; step();
        repeat (RSTC) step();
        pr_req_i = 1; step();
        chk("retrig.rel_hold", int'(state_o), 4);
        pr_req_i = 0; step();
        in_shutdown_i = 0; step();
        step();
        chk("retrig.idle", int'(state_o), 0);
        chk("retrig.cnt", int'(reconf_cnt_o), (c0 + 1) % (1 << CW));

        // Counter wrap.
        c0 = m_cnt;
        repeat (1 << CW) full_seq();
        chk("wrap.cnt", int'(reconf_cnt_o), c0);

        // Asynchronous reset in the middle of RMRST.
        pr_req_i = 1; step();
        in_shutdown_i = 1; step();
        pr_req_i = 0; step();
        repeat (5) step();
        #3 rstn = 0;
        model_reset();
        #1;
        chk("arst1.outs", int'({request_shutdown_o, decouple_o, rm_rstn_o}), 0);
        chk("arst1.state", int'(state_o), 0);
        chk("arst1.cnt", int'(reconf_cnt_o), 0);
        pr_req_i = 1; in_shutdown_i = 0;
        repeat (2) @(posedge clk100);
        #3 rstn = 1;
        step();
        chk("arst1.restart", int'(state_o), 1);

        // Asynchronous reset while in FAULT.
        n = 0;
        while (state_o != 3'd7 && n < TMO + 50) begin step(); n++; end
        chk("arst2.in_fault", int'(state_o), 7);
        #3 rstn = 0;
        model_reset();
        #1;
        chk("arst2.outs", int'({request_shutdown_o, decouple_o, rm_rstn_o}), 0);
        chk("arst2.fault", int'(fault_o), 0);
        chk("arst2.state", int'(state_o), 0);
        pr_req_i = 0;
        @(posedge clk100);
        #3 rstn = 1;
        step();
        chk("arst2.idle_rmrstn", int'(rm_rstn_o), 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) pr_req_i = ~pr_req_i;
            if ($urandom_range(0, 3) == 0) in_shutdown_i = ~in_shutdown_i;
            clr_fault_i = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
